imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter WORDS, default 64, instruction memory depth in 32-bit words; legal range 1..65535.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-004 start  input  1  single-cycle request to begin a program load.
REQ-005 byte_valid  input  1  loader byte stream valid.
REQ-006 byte_data  input  8  loader byte stream data.
REQ-007 byte_ready  output  1  block accepts byte this cycle; a transfer occurs when byte_valid and byte_ready are both 1.
REQ-008 mem_we  output  1  instruction memory write strobe, one cycle per word.
REQ-009 mem_waddr  output  32  byte address of written word, always word-aligned (bits 1:0 = 0).
REQ-010 mem_wdata  output  32  word written to instruction memory.
REQ-011 core_reset  output  1  active-high reset to core and instruction memory read port; 1 holds core.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  last load completed successfully.
REQ-014 error  output  1  last load rejected.

Function
REQ-015 States SHALL be IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR.
REQ-016 Stream format SHALL be: 16-bit word count N little-endian (LEN_LO then LEN_HI), then N words of 4 bytes each, least-significant byte first.
REQ-017 byte_ready SHALL be 1 only in LEN_LO, LEN_HI, DATA; 0 in IDLE, WRITE, DONE, ERROR.
REQ-018 IDLE, DONE or ERROR with start=1 SHALL go to LEN_LO next cycle, clear word index, byte counter, done and error; start is ignored in every other state.
REQ-019 LEN_LO on transfer: capture N[7:0], go LEN_HI.
REQ-020 LEN_HI on transfer: capture N[15:8]; N=0 -> DONE; N>WORDS -> ERROR; else DATA.
REQ-021 DATA: each transfer places byte k (k=0..3) into bits 8k+7:8k of the assembly register; after k=3 transfer go WRITE.
REQ-022 WRITE: mem_we=1 for exactly that cycle, mem_waddr = word_index*4, mem_wdata = assembled word; then word_index increments; if new word_index equals N go DONE, else DATA.
REQ-023 mem_we SHALL be 0 in every state except WRITE; mem_waddr/mem_wdata are don't-care when mem_we=0 but SHALL hold last values.
REQ-024 Word index SHALL never exceed WORDS-1 when mem_we=1 (guaranteed by REQ-020).
REQ-025 byte_valid with byte_ready=0 SHALL not consume the byte; absence of byte_valid stalls indefinitely with no state change.
REQ-026 busy SHALL be 1 in LEN_LO, LEN_HI, DATA, WRITE; 0 otherwise.
REQ-027 done SHALL be 1 only in DONE; error SHALL be 1 only in ERROR.
REQ-028 core_reset SHALL be 0 only in DONE; 1 in all other states, so the core never runs from a partially loaded memory.
REQ-029 start coincident with a transfer in LEN_LO..DATA SHALL be ignored and the transfer processed normally.
REQ-030 No restart mid-load except via reset.

Reset
REQ-031 reset=0 SHALL force, without waiting for clk: state IDLE, core_reset=1, mem_we=0, byte_ready=0, busy=0, done=0, error=0, mem_waddr=0, mem_wdata=0, word index, byte counter and N cleared.
REQ-032 reset asserted mid-load SHALL abandon the load; no further mem_we until a new start after reset release.

Verification
REQ-033 start; bytes 02 00 13 00 00 00 93 00 10 00 -> mem_we at addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093; DONE, done=1, core_reset=0.
REQ-034 start; bytes 00 00 -> DONE directly, no mem_we pulse, core_reset=0.
REQ-035 WORDS=64; start; bytes 41 00 -> ERROR, error=1, core_reset=1, byte_ready=0, no mem_we.
REQ-036 Load of 1 word with byte_valid toggling 1,0,0,1,... -> only valid&&ready bytes consumed; single write addr 0x0 with correct word; start during load ignored.
REQ-037 reset=0 asserted after 2 of 4 data bytes -> outputs at reset values immediately; after release, no mem_we until start; fresh load then completes correctly.
REQ-038 From DONE, start and 64-word load -> last write at addr 0xFC, done=1; core_reset=1 throughout reload until DONE.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction memory loader: parses a length-prefixed byte stream into
// 32-bit words, writes them to IMEM, and releases core reset on success.
//
// Ports:
//   clk, reset (async active-low)  - clock and reset
//   start                          - begin a new load (idle/done/error only)
//   byte_valid, byte_data          - incoming byte stream
//   byte_ready                     - byte accepted when valid && ready
//   mem_we, mem_waddr, mem_wdata   - IMEM write port (one cycle per word)
//   core_reset                     - holds the core unless a load completed
//   busy, done, error              - load status
module imem_loader #(
    parameter int WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        core_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    localparam logic [16:0] MAX_WORDS = 17'(WORDS);

    logic [2:0]  state;
    logic [15:0] n_words;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_q;
    logic        xfer;
    logic [15:0] new_n;
    logic [15:0] next_idx;

    assign byte_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                        (state == S_DATA);
    assign xfer       = byte_valid && byte_ready;
    assign mem_we     = (state == S_WRITE);
    assign busy       = byte_ready || (state == S_WRITE);
    assign done       = (state == S_DONE);
    assign error      = (state == S_ERROR);
    assign core_reset = (state != S_DONE);
    assign new_n      = {byte_data, n_words[7:0]};
    assign next_idx   = word_idx + 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            n_words   <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            asm_q     <= '0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state    <= S_LEN_LO;
                        word_idx <= '0;
                        byte_cnt <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        n_words[7:0] <= byte_data;
                        state        <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        n_words[15:8] <= byte_data;
                        if (new_n == 16'd0)
                            state <= S_DONE;
                        else if ({1'b0, new_n} > MAX_WORDS)
                            state <= S_ERROR;
                        else
                            state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: asm_q[7:0]   <= byte_data;
                            2'd1: asm_q[15:8]  <= byte_data;
                            2'd2: asm_q[23:16] <= byte_data;
                            default: begin
                                // Latch the full word and its address now so
                                // they stay on the port after the write.
                                mem_wdata <= {byte_data, asm_q};
                                mem_waddr <= {14'd0, word_idx, 2'b00};
                                state     <= S_WRITE;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    word_idx <= next_idx;
                    if (next_idx == n_words)
                        state <= S_DONE;
                    else
                        state <= S_DATA;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
